alu_master: RTL
===============

ALU_MASTER -- requirements
Module: alu_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum cycles to wait for alu_done before abandoning an operation (range 2..255).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset==0 resets).
REQ-004 SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 SHALL have port cmd_ready  output  1  block accepts a command this cycle.
REQ-006 SHALL have port cmd_op  input  op_t (simplealu_pkg)  requested ALU operation, passed opaquely.
REQ-007 SHALL have port cmd_a  input  8  operand A.
REQ-008 SHALL have port cmd_b  input  8  operand B.
REQ-009 SHALL have port alu_start  output  1  ALU start, level-held for the whole operation.
REQ-010 SHALL have port alu_op  output  op_t  operation presented to ALU.
REQ-011 SHALL have port alu_a  output  8  operand A presented to ALU.
REQ-012 SHALL have port alu_b  output  8  operand B presented to ALU.
REQ-013 SHALL have port alu_result  input  16  ALU result, valid when alu_done==1.
REQ-014 SHALL have port alu_done  input  1  ALU completion strobe.
REQ-015 SHALL have port rsp_valid  output  1  response available.
REQ-016 SHALL have port rsp_ready  input  1  downstream accepts response.
REQ-017 SHALL have port rsp_result  output  16  captured result.
REQ-018 SHALL have port rsp_timeout  output  1  response is a timeout, not a real result.
REQ-019 SHALL have port op_count  output  16  completed (non-timeout) operations, saturating.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, RESP; one-hot or binary encoding at implementer's choice.
REQ-021 cmd_ready SHALL equal 1 exactly when state==IDLE (combinational from state only, no dependency on cmd_valid).
REQ-022 Handshake cmd_valid&&cmd_ready at edge N SHALL register cmd_op/cmd_a/cmd_b into alu_op/alu_a/alu_b and enter BUSY; alu_start SHALL be 1 from cycle N+1.
REQ-023 alu_op/alu_a/alu_b SHALL remain stable throughout BUSY and RESP; change only on a new command accept.
REQ-024 In BUSY, alu_done==1 sampled at edge M SHALL capture alu_result into rsp_result, clear rsp_timeout, enter RESP; alu_start SHALL be 0 from M+1.
REQ-025 alu_done SHALL be ignored in IDLE and RESP.
REQ-026 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without done; when it reaches TIMEOUT_CYCLES-1 with alu_done==0, next edge SHALL enter RESP with rsp_timeout=1, rsp_result=16'h0000, alu_start=0.
REQ-027 alu_done and the timeout condition in the same cycle SHALL resolve as done (real result, rsp_timeout=0).
REQ-028 rsp_valid SHALL equal 1 exactly when state==RESP; rsp_result/rsp_timeout SHALL be stable while rsp_valid==1.
REQ-029 RESP SHALL exit to IDLE on the edge where rsp_ready==1; a new command SHALL not be accepted in that same cycle (earliest accept is next cycle).
REQ-030 op_count SHALL increment by 1 on each BUSY->RESP transition with rsp_timeout=0, saturating at 16'hFFFF.
REQ-031 Minimum command-to-command period SHALL be: 1 accept + ALU latency + 1 RESP + 1 IDLE cycle.

Reset
REQ-032 reset==0 SHALL asynchronously force: state=IDLE, alu_start=0, alu_op=op_t'(0), alu_a=0, alu_b=0, rsp_result=0, rsp_timeout=0, op_count=0, wait counter=0.
REQ-033 Reset asserted mid-BUSY or mid-RESP SHALL abandon the operation with no response produced; alu_start SHALL drop immediately.
REQ-034 After reset deasserts, cmd_ready SHALL be 1 on the first clock edge.

Verification
REQ-035 Basic: cmd a=8'h12,b=8'h34, ALU done 3 cycles after start with result 16'h0046 -> rsp_valid=1, rsp_result=16'h0046, rsp_timeout=0, op_count=1.
REQ-036 Backpressure: rsp_ready held 0 for 5 cycles after response -> rsp_valid/rsp_result stable, cmd_ready=0 throughout; accept resumes the cycle after rsp_ready=1.
REQ-037 Timeout: TIMEOUT_CYCLES=8, alu_done never asserted -> alu_start high 8 cycles then 0, rsp_timeout=1, rsp_result=0, op_count unchanged.
REQ-038 Race: alu_done asserted in the final timeout cycle with result 16'hBEEF -> rsp_timeout=0, rsp_result=16'hBEEF.
REQ-039 Reset mid-op: reset pulled low 2 cycles into BUSY -> alu_start=0 asynchronously, no rsp_valid, op_count=0, cmd_ready=1 after release.
REQ-040 Saturation: preload/force 65535 completions -> further completions leave op_count=16'hFFFF.

Source files
------------

// File: rtl/alu_master.sv
// ALU master: accepts one command at a time, holds it on the ALU port until
// the ALU reports done (or a wait limit expires), then presents a single
// response to the downstream side and counts successful operations.

package simplealu_pkg;

    // Operation code carried to the ALU; this block never interprets it.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5
    } op_t;

endpackage

module alu_master
    import simplealu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  op_t         cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output op_t         alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_timeout,
    output logic [15:0] op_count
);

    // Last wait-counter value before the operation is abandoned. The
    // counter starts at 0 in the first BUSY cycle, so BUSY lasts exactly
    // TIMEOUT_CYCLES cycles when the ALU never answers.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    op_t         aluOp_q,       aluOp_d;
    logic [7:0]  aluA_q,        aluA_d;
    logic [7:0]  aluB_q,        aluB_d;
    logic [15:0] rspResult_q,   rspResult_d;
    logic        rspTimeout_q,  rspTimeout_d;
    logic [15:0] opCount_q,     opCount_d;
    logic [7:0]  waitCnt_q,     waitCnt_d;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            aluOp_q      <= op_t'(0);
            aluA_q       <= 8'h00;
            aluB_q       <= 8'h00;
            rspResult_q  <= 16'h0000;
            rspTimeout_q <= 1'b0;
            opCount_q    <= 16'h0000;
            waitCnt_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            aluOp_q      <= aluOp_d;
            aluA_q       <= aluA_d;
            aluB_q       <= aluB_d;
            rspResult_q  <= rspResult_d;
            rspTimeout_q <= rspTimeout_d;
            opCount_q    <= opCount_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for done or timeout in BUSY
    // (done wins a tie), hold the response in RESP until it is taken.
    always_comb begin
        state_d      = state_q;
        aluOp_d      = aluOp_q;
        aluA_d       = aluA_q;
        aluB_d       = aluB_q;
        rspResult_d  = rspResult_q;
        rspTimeout_d = rspTimeout_q;
        opCount_d    = opCount_q;
        waitCnt_d    = waitCnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    aluOp_d   = cmd_op;
                    aluA_d    = cmd_a;
                    aluB_d    = cmd_b;
                    waitCnt_d = 8'h00;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (alu_done) begin
                    rspResult_d  = alu_result;
                    rspTimeout_d = 1'b0;
                    if (opCount_q != 16'hFFFF) begin
                        opCount_d = opCount_q + 16'd1;
                    end
                    state_d = RESP;
                end else if (waitCnt_q == WAIT_LAST) begin
                    rspResult_d  = 16'h0000;
                    rspTimeout_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode straight from the state register so that
    // alu_start falls the instant reset is applied.
    assign cmd_ready   = (state_q == IDLE);
    assign alu_start   = (state_q == BUSY);
    assign rsp_valid   = (state_q == RESP);

    assign alu_op      = aluOp_q;
    assign alu_a       = aluA_q;
    assign alu_b       = aluB_q;
    assign rsp_result  = rspResult_q;
    assign rsp_timeout = rspTimeout_q;
    assign op_count    = opCount_q;

endmodule
